// File: rtl/q_value_selector.sv
// q_value_selector: captures one forward pass of node values and reports the argmax action over the output-layer Q values.
module q_value_selector #(
    parameter int DATA_WIDTH                    = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    localparam int TOTAL_NODE = NUMBER_OF_HIDDEN_NODE_LAYER_1 + NUMBER_OF_HIDDEN_NODE_LAYER_2 + NUMBER_OF_OUTPUT_NODE,
    localparam int ADDR_WIDTH = $clog2(TOTAL_NODE),
    localparam int ACT_WIDTH  = $clog2(NUMBER_OF_OUTPUT_NODE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ACT_WIDTH-1:0]  o_action,
    output logic [DATA_WIDTH-1:0] o_max_q,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_error
);
    typedef enum logic [1:0] {IDLE, COLLECT, SELECT, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   TOTAL_W  = (ADDR_WIDTH+1)'(TOTAL_NODE);
    localparam logic [ADDR_WIDTH-1:0] OUT_BASE = ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_1 + NUMBER_OF_HIDDEN_NODE_LAYER_2);
    localparam logic [ACT_WIDTH-1:0]  LAST_K   = ACT_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

    logic [DATA_WIDTH-1:0] store_q [TOTAL_NODE];
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ACT_WIDTH-1:0]  k_q, k_d;
    logic [DATA_WIDTH-1:0] best_q_q, best_q_d;
    logic [ACT_WIDTH-1:0]  best_idx_q, best_idx_d;
    logic [ACT_WIDTH-1:0]  action_q, action_d;
    logic [DATA_WIDTH-1:0] max_q_q, max_q_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  we, accepting, in_range;
    logic [DATA_WIDTH-1:0] sel_val;

    assign accepting = (state_q == IDLE) || (state_q == COLLECT);
    assign in_range  = {1'b0, i_data_addr} < TOTAL_W;
    assign sel_val   = store_q[OUT_BASE + ADDR_WIDTH'(k_q)];
    assign rd_data_d = ({1'b0, i_rd_addr} < TOTAL_W) ? store_q[i_rd_addr] : '0;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        k_d        = k_q;
        best_q_d   = best_q_q;
        best_idx_d = best_idx_q;
        action_d   = action_q;
        max_q_d    = max_q_q;
        valid_d    = 1'b0;
        error_d    = error_q;
        we         = 1'b0;
        if (i_clear) begin
            state_d = IDLE;
            count_d = '0;
            error_d = 1'b0;
        end else begin
            // Out-of-range addresses and valids outside a collection window are protocol errors.
            if (i_valid && (!accepting || !in_range))
                error_d = 1'b1;
            we = i_valid && accepting && in_range;
            case (state_q)
                IDLE: if (we) begin
                    count_d = (ADDR_WIDTH+1)'(1);
                    state_d = COLLECT;
                end
                COLLECT: if (we) begin
                    count_d = count_q + 1'b1;
                    if (count_d == TOTAL_W) begin
                        state_d = SELECT;
                        k_d     = '0;
                    end
                end
                SELECT: begin
                    if (k_q == '0 || $signed(sel_val) > $signed(best_q_q)) begin
                        best_q_d   = sel_val;
                        best_idx_d = k_q;
                    end
                    k_d = k_q + 1'b1;
                    if (k_q == LAST_K)
                        state_d = DONE;
                end
                DONE: begin
                    action_d = best_idx_q;
                    max_q_d  = best_q_q;
                    valid_d  = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk)
        if (we)
            store_q[i_data_addr] <= i_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            k_q        <= '0;
            best_q_q   <= '0;
            best_idx_q <= '0;
            action_q   <= '0;
            max_q_q    <= '0;
            rd_data_q  <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            k_q        <= k_d;
            best_q_q   <= best_q_d;
            best_idx_q <= best_idx_d;
            action_q   <= action_d;
            max_q_q    <= max_q_d;
            rd_data_q  <= rd_data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_action  = action_q;
    assign o_max_q   = max_q_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q == SELECT);
    assign o_error   = error_q;
endmodule

// File: tb/tb_q_value_selector.sv
// tb_q_value_selector: directed passes with a result scoreboard drained by an o_valid monitor.
module tb_q_value_selector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_valid = 1'b0;
    logic [6:0]  i_data_addr = '0;
    logic [31:0] i_data = '0;
    logic [6:0]  i_rd_addr = '0;
    logic [31:0] o_rd_data;
    logic [1:0]  o_action;
    logic [31:0] o_max_q;
    logic        o_valid, o_busy, o_error;

    typedef struct {
        logic [1:0]  act;
        logic [31:0] q;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    q_value_selector dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_data_addr(i_data_addr), .i_data(i_data), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_action(o_action), .o_max_q(o_max_q),
        .o_valid(o_valid), .o_busy(o_busy), .o_error(o_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("action", 64'(o_action), 64'(e.act));
                chk("max_q", 64'(o_max_q), 64'(e.q));
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        i_valid = 1'b1; i_data_addr = a; i_data = d;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    // bad_at >= 0 inserts an address-67 valid before node bad_at; inj issues a valid during SELECT.
    task automatic run_pass(input logic [31:0] q0, input logic [31:0] q1, input logic [31:0] q2,
                            input logic [1:0] ea, input logic [31:0] eq, input int bad_at, input bit inj);
        for (int i = 0; i < 67; i++) begin
            if (i == bad_at) begin
                send(7'd67, 32'hDEAD_BEEF);
                idle();
                @(negedge clk);
                chk("err_out_of_range", 64'(o_error), 64'd1);
            end
            send(7'(i), i < 64 ? 32'(i) : (i == 64 ? q0 : (i == 65 ? q1 : q2)));
        end
        sb.push_back('{act: ea, q: eq, due: cyc + 5});
        if (inj) begin
            send(7'd5, 32'd999);
            idle();
            @(negedge clk);
            chk("err_in_select", 64'(o_error), 64'd1);
        end else begin
            idle();
            @(negedge clk);
            chk("busy_select", 64'(o_busy), 64'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic readback(input logic [6:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        i_rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("rd_%0d", a), 64'(o_rd_data), 64'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_error"}, 64'(o_error), 64'd0);
        chk({tag, "_action"}, 64'(o_action), 64'd0);
        chk({tag, "_max_q"}, 64'(o_max_q), 64'd0);
        chk({tag, "_rd_data"}, 64'(o_rd_data), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #20;
        check_reset_outputs("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        run_pass(-32'sd5, 32'd7, 32'd7, 2'd1, 32'd7, -1, 1'b0);
        drain();
        chk("no_error_pass1", 64'(o_error), 64'd0);
        chk("busy_idle", 64'(o_busy), 64'd0);
        readback(7'd10, 32'd10);
        readback(7'd66, 32'd7);

        run_pass(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 2'd1, 32'hFFFF_FFFF, -1, 1'b0);
        drain();
        readback(7'd66, 32'h8000_0001);
        readback(7'd64, 32'h8000_0000);

        run_pass(32'd9, 32'd2, 32'd9, 2'd0, 32'd9, -1, 1'b1);
        drain();
        chk("err_sticky", 64'(o_error), 64'd1);
        readback(7'd5, 32'd5);
        @(posedge clk); #1 i_clear = 1'b1;
        @(posedge clk); #1 i_clear = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(o_error), 64'd0);
        chk("clear_idle", 64'(o_busy), 64'd0);

        run_pass(32'd1, 32'hFFFF_FFFF, 32'd2, 2'd2, 32'd2, 10, 1'b0);
        drain();
        chk("err_after_range", 64'(o_error), 64'd1);
        @(posedge clk); #1 i_clear = 1'b1;
        @(posedge clk); #1 i_clear = 1'b0;

        for (int i = 0; i < 40; i++) send(7'(i), 32'(i));
        idle();
        #1 rst_n = 1'b0;
        #3;
        check_reset_outputs("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_pass(32'd4, -32'sd8, 32'd4, 2'd0, 32'd4, -1, 1'b0);
        drain();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_no_pending", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/q_value_selector.md
Name: q_value_selector

Overview:
- Sits directly downstream of the feed-forward network output stream, which emits one node value per valid cycle in order: hidden layer 1, hidden layer 2, then the output layer.
- Captures every node value of one forward pass into an internal activation store, for later readback by the backpropagation logic.
- Once the pass is complete, scans the output-layer Q values and reports the greedy action (argmax) and its Q value.

Parameters:
- DATA_WIDTH, 32, width of one signed two's-complement fixed-point node value.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, node count of hidden layer 1.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, node count of hidden layer 2.
- NUMBER_OF_OUTPUT_NODE, 3, number of Q values (actions); must be >= 2.
- TOTAL_NODE (local), sum of the three node counts.
- ADDR_WIDTH (local), $clog2(TOTAL_NODE).
- ACT_WIDTH (local), $clog2(NUMBER_OF_OUTPUT_NODE).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- i_clear, input, 1, synchronous abort of the current pass.
- i_valid, input, 1, node value present on i_data and i_data_addr this cycle.
- i_data_addr, input, ADDR_WIDTH, node index 0..TOTAL_NODE-1; the integrator truncates any wider upstream bus to this width.
- i_data, input, DATA_WIDTH, node value.
- i_rd_addr, input, ADDR_WIDTH, readback address for the activation store.
- o_rd_data, output, DATA_WIDTH, registered readback data.
- o_action, output, ACT_WIDTH, argmax output-node index.
- o_max_q, output, DATA_WIDTH, Q value at o_action.
- o_valid, output, 1, one-cycle pulse; o_action and o_max_q are valid.
- o_busy, output, 1, high in SELECT.
- o_error, output, 1, sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE; received-count goes to 0.
  - o_valid, o_busy, o_error, o_action, o_max_q and o_rd_data all go to 0.
  - Store contents are don't-care; reset does not clear them.
- Storage:
  - TOTAL_NODE x DATA_WIDTH register array.
  - A sampled i_valid writes i_data to store[i_data_addr] at that edge.
  - In IDLE or COLLECT, a valid with i_data_addr >= TOTAL_NODE is not written, is not counted, and sets o_error.
- Readback: o_rd_data <= store[i_rd_addr] every cycle; 1-cycle latency. A same-cycle write to the same address returns the old value.
- State machine:
  - IDLE: on i_valid, store the value, set count to 1, go to COLLECT.
  - COLLECT: on each i_valid, store the value and increment count. When the edge that samples the valid brings count to TOTAL_NODE, go to SELECT with scan index 0.
  - SELECT:
    - One output node per cycle, index k = 0..NUMBER_OF_OUTPUT_NODE-1, reading store[NUMBER_OF_HIDDEN_NODE_LAYER_1 + NUMBER_OF_HIDDEN_NODE_LAYER_2 + k].
    - k=0 loads best_q and best_idx unconditionally.
    - For k>0, best is replaced only if the value is strictly greater, using signed compare. Ties keep the lowest index.
    - After the last k, go to DONE.
  - DONE: o_action <= best_idx, o_max_q <= best_q, o_valid <= 1 for exactly one cycle, count <= 0, go to IDLE.
- Latency: o_valid rises NUMBER_OF_OUTPUT_NODE+1 edges after the edge sampling the last valid. With the default of 3 output nodes, that is 4 edges.
- o_action and o_max_q hold their values until the next DONE.
- o_busy = (state == SELECT).
- i_valid during SELECT or DONE: ignored (not written, not counted); sets o_error.
- Duplicate addresses within a pass are not detected: the later value overwrites, and count still increments.
- i_clear:
  - In any state, at the next edge: state <= IDLE, count <= 0, o_valid <= 0, o_error <= 0.
  - Any i_valid in the same cycle is dropped.
  - i_clear is the only way to clear o_error other than reset.
- rst_n asserted mid-pass aborts immediately. No o_valid is produced for that pass.

Test Plan:
- Reset, then stream nodes 0..66 with value = index, output nodes last with values -5, 7, 7 -> exactly one o_valid pulse, 4 edges after the last input; o_action=1, o_max_q=7; o_error=0.
- Output values 0x80000000, 0xFFFFFFFF, 0x80000001 (signed) -> o_action=1, o_max_q=0xFFFFFFFF.
- After a full pass, set i_rd_addr=10 -> o_rd_data=10 on the next cycle. Set i_rd_addr=66 -> o_rd_data = last output value.
- Inject i_valid during SELECT -> o_error=1 and sticky; result unchanged. Then pulse i_clear -> o_error=0 and state IDLE.
- Send i_data_addr=67 in COLLECT -> o_error=1 and count unchanged; the pass still needs 67 in-range values before o_valid.
- Assert rst_n=0 after 40 values, release, then send a full pass -> all outputs read 0 during reset; exactly one o_valid pulse, for the new pass only.
